// File: rtl/chan_array_fifo.sv
// -----------------------------------------------------------------------------
// chan_array_fifo
//   Bank of NUM_CH independent FIFOs, each DEPTH entries of WIDTH bits, with
//   show-ahead output and sticky per-channel overflow/underflow flags.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   push     in   [NUM_CH]      per-channel write request
//   din      in   [WIDTH] x NUM_CH  per-channel write data
//   pop      in   [NUM_CH]      per-channel read request
//   dout     out  [WIDTH] x NUM_CH  head entry of each channel, 0 when empty
//   empty    out  [NUM_CH]      channel holds no entries
//   full     out  [NUM_CH]      channel holds DEPTH entries
//   count    out  [CW] x NUM_CH entries held per channel
//   ovf_err  out  [NUM_CH]      sticky: a push was refused
//   unf_err  out  [NUM_CH]      sticky: a pop hit an empty channel
//   clr_err  in   [NUM_CH]      clears both sticky flags of selected channels
// -----------------------------------------------------------------------------
module chan_array_fifo #(
   parameter int unsigned  NUM_CH = 4,
   parameter int unsigned  WIDTH  = 8,
   parameter int unsigned  DEPTH  = 4,
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] push,
   input  logic [WIDTH-1:0]  din     [NUM_CH],
   input  logic [NUM_CH-1:0] pop,
   output logic [WIDTH-1:0]  dout    [NUM_CH],
   output logic [NUM_CH-1:0] empty,
   output logic [NUM_CH-1:0] full,
   output logic [CW-1:0]     count   [NUM_CH],
   output logic [NUM_CH-1:0] ovf_err,
   output logic [NUM_CH-1:0] unf_err,
   input  logic [NUM_CH-1:0] clr_err
);

   localparam int unsigned PW = $clog2(DEPTH);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_rd_ptr;
      logic [PW-1:0]    r_wr_ptr;
      logic [CW-1:0]    r_count;
      logic             r_ovf;
      logic             r_unf;

      logic [CW-1:0]    w_count_nxt;
      logic             w_ovf_nxt;
      logic             w_unf_nxt;
      logic             w_empty;
      logic             w_full;
      logic             w_pop_acc;
      logic             w_push_acc;
      logic             w_ovf_evt;
      logic             w_unf_evt;

      // Status comes only from the registered count, so no input reaches an output.
      assign w_empty = (r_count == '0);
      assign w_full  = (r_count == CW'(DEPTH));

      // A same-cycle pop frees a slot on a full channel; an empty channel never
      // forwards a same-cycle push to a pop.
      assign w_pop_acc  = pop[g] & ~w_empty;
      assign w_push_acc = push[g] & (~w_full | w_pop_acc);
      assign w_ovf_evt  = push[g] & w_full & ~w_pop_acc;
      assign w_unf_evt  = pop[g] & w_empty;

      always_comb begin
         w_count_nxt = r_count;
         if (w_push_acc && !w_pop_acc) begin
            w_count_nxt = r_count + CW'(1);
         end else if (w_pop_acc && !w_push_acc) begin
            w_count_nxt = r_count - CW'(1);
         end
      end

      // A new error event wins over a clear in the same cycle.
      always_comb begin
         w_ovf_nxt = r_ovf;
         w_unf_nxt = r_unf;
         if (clr_err[g]) begin
            w_ovf_nxt = 1'b0;
            w_unf_nxt = 1'b0;
         end
         if (w_ovf_evt) begin
            w_ovf_nxt = 1'b1;
         end
         if (w_unf_evt) begin
            w_unf_nxt = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
         end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_push_acc) begin
               r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_acc) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
         end
      end

      // Storage is not reset; entries are only visible once counted.
      always_ff @(posedge clk) begin
         if (w_push_acc) begin
            r_mem[r_wr_ptr] <= din[g];
         end
      end

      assign dout[g]    = w_empty ? '0 : r_mem[r_rd_ptr];
      assign count[g]   = r_count;
      assign empty[g]   = w_empty;
      assign full[g]    = w_full;
      assign ovf_err[g] = r_ovf;
      assign unf_err[g] = r_unf;
   end

endmodule

// File: tb/tb_chan_array_fifo.sv
// -----------------------------------------------------------------------------
// tb_chan_array_fifo
//   Scenario-driven bench for chan_array_fifo (NUM_CH=4, WIDTH=8, DEPTH=4).
//   A per-channel queue holds the data expected to come out; each popped or
//   displayed head entry is compared against it.
// -----------------------------------------------------------------------------
module tb_chan_array_fifo;

   localparam int NCH = 4;
   localparam int W   = 8;
   localparam int D   = 4;
   localparam int CWT = $clog2(D + 1);

   logic           clk;
   logic           rst;
   logic [NCH-1:0] push;
   logic [W-1:0]   din     [NCH];
   logic [NCH-1:0] pop;
   logic [W-1:0]   dout    [NCH];
   logic [NCH-1:0] empty;
   logic [NCH-1:0] full;
   logic [CWT-1:0] count   [NCH];
   logic [NCH-1:0] ovf_err;
   logic [NCH-1:0] unf_err;
   logic [NCH-1:0] clr_err;

   int checks;
   int failures;

   // Reference model: expected contents and sticky flags per channel.
   logic [W-1:0] sb [NCH][$];
   bit           m_ovf [NCH];
   bit           m_unf [NCH];

   chan_array_fifo #(
      .NUM_CH (NCH),
      .WIDTH  (W),
      .DEPTH  (D)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .din     (din),
      .pop     (pop),
      .dout    (dout),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .ovf_err (ovf_err),
      .unf_err (unf_err),
      .clr_err (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      rst     = 1'b0;
      push    = '0;
      pop     = '0;
      clr_err = '0;
      for (int c = 0; c < NCH; c++) din[c] = '0;
   endtask

   // Apply current inputs for one clock; update the model and compare data.
   task automatic step();
      logic [W-1:0] exp;
      bit           pa;
      int           sz;
      for (int c = 0; c < NCH; c++) begin
         if (rst) begin
            sb[c].delete();
            m_ovf[c] = 1'b0;
            m_unf[c] = 1'b0;
         end else begin
            sz = sb[c].size();
            pa = pop[c] && (sz > 0);
            if (pa) begin
               exp = sb[c].pop_front();
               checks++;
               if (dout[c] !== exp) begin
                  failures++;
                  $display("FAIL pop_data ch%0d: got %02h expected %02h", c, dout[c], exp);
               end
            end
            if (push[c] && ((sz < D) || pa)) sb[c].push_back(din[c]);
            if (push[c] && (sz == D) && !pa) m_ovf[c] = 1'b1;
            else if (clr_err[c]) m_ovf[c] = 1'b0;
            if (pop[c] && (sz == 0)) m_unf[c] = 1'b1;
            else if (clr_err[c]) m_unf[c] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         exp = (sb[c].size() > 0) ? sb[c][0] : '0;
         checks++;
         if (dout[c] !== exp) begin
            failures++;
            $display("FAIL head_data ch%0d: got %02h expected %02h", c, dout[c], exp);
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (count[c] !== '0 || empty[c] !== 1'b1 || full[c] !== 1'b0 ||
             ovf_err[c] !== 1'b0 || unf_err[c] !== 1'b0 || dout[c] !== '0) begin
            failures++;
            $display("FAIL reset_state ch%0d: got cnt=%0d e=%b f=%b o=%b u=%b d=%02h expected 0 1 0 0 0 00",
                     c, count[c], empty[c], full[c], ovf_err[c], unf_err[c], dout[c]);
         end
      end
   endtask

   task automatic test_fill();
      logic [W-1:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         push[2] = 1'b1;
         din[2]  = vals[i];
         step();
      end
      idle_inputs();
      checks++;
      if (count[2] !== CWT'(4) || full[2] !== 1'b1 || dout[2] !== 8'h11) begin
         failures++;
         $display("FAIL fill_ch2: got cnt=%0d full=%b dout=%02h expected 4 1 11",
                  count[2], full[2], dout[2]);
      end
      for (int c = 0; c < NCH; c++) begin
         if (c == 2) continue;
         checks++;
         if (empty[c] !== 1'b1 || count[c] !== '0) begin
            failures++;
            $display("FAIL fill_other ch%0d: got empty=%b cnt=%0d expected 1 0", c, empty[c], count[c]);
         end
      end
   endtask

   task automatic test_overflow();
      idle_inputs();
      push[2] = 1'b1;
      din[2]  = 8'h55;
      step();
      idle_inputs();
      checks++;
      if (ovf_err[2] !== 1'b1 || count[2] !== CWT'(4) || dout[2] !== 8'h11) begin
         failures++;
         $display("FAIL ovf_refused: got ovf=%b cnt=%0d dout=%02h expected 1 4 11",
                  ovf_err[2], count[2], dout[2]);
      end
      push[2] = 1'b1;
      pop[2]  = 1'b1;
      din[2]  = 8'h55;
      step();
      idle_inputs();
      checks++;
      if (count[2] !== CWT'(4) || dout[2] !== 8'h22 || full[2] !== 1'b1) begin
         failures++;
         $display("FAIL full_push_pop: got cnt=%0d dout=%02h full=%b expected 4 22 1",
                  count[2], dout[2], full[2]);
      end
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         pop[2] = 1'b1;
         step();
      end
      idle_inputs();
      checks++;
      if (empty[2] !== 1'b1 || dout[2] !== '0 || unf_err[2] !== 1'b0) begin
         failures++;
         $display("FAIL drain_ch2: got empty=%b dout=%02h unf=%b expected 1 00 0",
                  empty[2], dout[2], unf_err[2]);
      end
      clr_err[2] = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (ovf_err[2] !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear: got %b expected 0", ovf_err[2]);
      end
   endtask

   task automatic test_underflow();
      idle_inputs();
      pop[0] = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (unf_err[0] !== 1'b1 || count[0] !== '0 || ovf_err[0] !== 1'b0) begin
         failures++;
         $display("FAIL unf_set: got unf=%b cnt=%0d ovf=%b expected 1 0 0",
                  unf_err[0], count[0], ovf_err[0]);
      end
      clr_err[0] = 1'b1;
      pop[0]     = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (unf_err[0] !== 1'b1) begin
         failures++;
         $display("FAIL unf_set_wins: got %b expected 1", unf_err[0]);
      end
      clr_err[0] = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (unf_err[0] !== 1'b0) begin
         failures++;
         $display("FAIL unf_clear: got %b expected 0", unf_err[0]);
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      push = '1;
      for (int c = 0; c < NCH; c++) din[c] = W'(c * 16 + 15);
      step();
      for (int cy = 0; cy < 10; cy++) begin
         idle_inputs();
         push = '1;
         pop  = '1;
         for (int c = 0; c < NCH; c++) din[c] = W'(c * 16 + cy);
         step();
         for (int c = 0; c < NCH; c++) begin
            checks++;
            if (count[c] !== CWT'(1)) begin
               failures++;
               $display("FAIL b2b_count ch%0d cyc%0d: got %0d expected 1", c, cy, count[c]);
            end
         end
      end
      idle_inputs();
      pop = '1;
      step();
      idle_inputs();
      checks++;
      if (empty !== '1) begin
         failures++;
         $display("FAIL b2b_drain: got empty=%b expected 1111", empty);
      end
   endtask

   task automatic test_reset_midstream();
      idle_inputs();
      pop[0] = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         push[1] = 1'b1;
         din[1]  = W'(8'ha0 + i);
         step();
      end
      idle_inputs();
      checks++;
      if (count[1] !== CWT'(3) || unf_err[0] !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got cnt1=%0d unf0=%b expected 3 1", count[1], unf_err[0]);
      end
      rst  = 1'b1;
      push = '1;
      pop  = '1;
      for (int c = 0; c < NCH; c++) din[c] = 8'hee;
      step();
      idle_inputs();
      checks++;
      if (count[1] !== '0 || empty[1] !== 1'b1 || dout[1] !== '0) begin
         failures++;
         $display("FAIL rst_mid_ch1: got cnt=%0d empty=%b dout=%02h expected 0 1 00",
                  count[1], empty[1], dout[1]);
      end
      checks++;
      if (ovf_err !== '0 || unf_err !== '0) begin
         failures++;
         $display("FAIL rst_mid_flags: got ovf=%b unf=%b expected 0000 0000", ovf_err, unf_err);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle_inputs();
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/chan_array_fifo.md
Name: chan_array_fifo

Overview:
- Parametrised multi-channel FIFO bank with NUM_CH independent channels, each DEPTH entries of WIDTH bits.
- Data ports are unpacked arrays indexed by channel; control and status ports are packed per-channel vectors.
- Sits between array-driving producer blocks and array-consuming blocks. It adds per-channel buffering, show-ahead output and sticky overflow/underflow flags.

Parameters:
- NUM_CH, 4, number of independent channels (≥1).
- WIDTH, 8, data bits per entry (≥1).
- DEPTH, 4, entries per channel (≥2, power of two).
- CW, $clog2(DEPTH+1), count width (derived, localparam).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- push  input  [NUM_CH-1:0]  per-channel write request.
- din  input  logic [WIDTH-1:0] din[NUM_CH]  per-channel write data.
- pop  input  [NUM_CH-1:0]  per-channel read request.
- dout  output  logic [WIDTH-1:0] dout[NUM_CH]  per-channel head entry (show-ahead).
- empty  output  [NUM_CH-1:0]  channel holds 0 entries.
- full  output  [NUM_CH-1:0]  channel holds DEPTH entries.
- count  output  logic [CW-1:0] count[NUM_CH]  entries held per channel.
- ovf_err  output  [NUM_CH-1:0]  sticky: push refused.
- unf_err  output  [NUM_CH-1:0]  sticky: pop on empty.
- clr_err  input  [NUM_CH-1:0]  clears the sticky flags of the selected channels.

Behaviour:
- Reset: for every channel, read/write pointers = 0, count = 0, empty = 1, full = 0, ovf_err = 0, unf_err = 0, dout = 0. Storage contents are don't-care. Reset overrides every other input in the same cycle.
- Channels are fully independent; no cross-channel arbitration.
- Per-channel push is accepted when push & (!full | pop_acc).
  - pop_acc = pop & !empty.
  - So push+pop on a full channel is accepted.
- Per-channel pop is accepted when pop & !empty.
  - A push on an empty channel does not satisfy a same-cycle pop; there is no bypass.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both accepted or neither: unchanged.
  - count never exceeds DEPTH and never underflows.
- Pointers are log2(DEPTH) bits and wrap from DEPTH−1 to 0. full and empty are derived from count, not from pointer compare.
- dout[ch] = mem[ch][rd_ptr] when !empty; 0 when empty.
  - Write-to-read latency: an entry pushed in cycle N is visible on dout in cycle N+1 if the channel was empty.
  - After an accepted pop, the next entry is visible the following cycle.
- Refused push (push & full & !pop_acc): data is dropped, state is unchanged, and ovf_err[ch] is set next cycle.
- Pop on empty: no state change, and unf_err[ch] is set next cycle.
- clr_err[ch] clears both flags next cycle. If an error event occurs in the same cycle, the set wins.
- empty, full and count are registered, or derived combinationally from registered count only. There is no combinational path from any input to any output.

Test Plan:
- Reset, then idle with NUM_CH=4, WIDTH=8, DEPTH=4 -> all empty=1, full=0, count=0, dout=0, ovf_err=unf_err=0.
- Push 0x11,0x22,0x33,0x44 into ch2 only -> count[2]=4, full[2]=1, dout[2]=0x11; ch0/1/3 remain empty.
- Fifth push 0x55 to full ch2 with no pop -> dropped, ovf_err[2]=1, count[2]=4. Then push 0x55 with pop in the same cycle -> count[2]=4, dout[2]=0x22; the later drain order is 22,33,44,55.
- Pop on empty ch0 -> unf_err[0]=1, count[0]=0. Assert clr_err[0] with a simultaneous empty pop -> flag stays 1. Assert clr_err[0] alone -> flag clears.
- Push and pop all four channels every cycle for 10 cycles, din[ch]=ch*16+cycle, after priming each channel with one entry -> counts stay at 1. Per-channel output order matches input order across pointer wrap.
- Assert rst while ch1 holds 3 entries and push/pop are active -> next cycle count[1]=0, empty[1]=1, dout[1]=0, error flags 0.
